// File: rtl/dcache_coh_ctrl_if.sv
// Cache <-> datapath / memory-controller link for dcache_coh_ctrl.
// The master modport is the cache. The slave modport is the datapath and controller side.
interface dcache_coh_ctrl_if;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        dhit;
  logic [31:0] dmemload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        ccwrite;
  logic        cctrans;
  logic        dwait;
  logic [31:0] dload;
  logic        ccwait;
  logic        ccinv;
  logic [31:0] ccsnoopaddr;

  modport master (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, dwait, dload, ccwait, ccinv, ccsnoopaddr,
    output dhit, dmemload, dREN, dWEN, daddr, dstore, ccwrite, cctrans
  );

  modport slave (
    output dmemREN, dmemWEN, dmemaddr, dmemstore, dwait, dload, ccwait, ccinv, ccsnoopaddr,
    input  dhit, dmemload, dREN, dWEN, daddr, dstore, ccwrite, cctrans
  );
endinterface

// File: rtl/dcache_coh_ctrl.sv
// Direct-mapped write-back L1 D-cache with 2-word blocks and MSI state per frame.
// It serves datapath loads and stores, and performs fills, writebacks, upgrades and snoop replies.
module dcache_coh_ctrl #(
  parameter int unsigned SETS = 8
) (
  input logic              CLK,
  input logic              nRST,
  dcache_coh_ctrl_if.master io_cif
);
  localparam int unsigned IW = $clog2(SETS);
  localparam int unsigned TW = 32 - IW - 3;

  typedef enum logic [1:0] {MsiI, MsiS, MsiM} msi_e;
  typedef enum logic [3:0] {
    StIdle, StWb0, StWb1, StLd0, StLd1, StUpg, StSnoop, StSwb0, StSwb1
  } state_e;

  state_e        r_state;
  msi_e          r_msi  [SETS];
  logic [TW-1:0] r_tag  [SETS];
  logic [31:0]   r_data [SETS][2];
  logic [IW-1:0] r_sidx;
  logic          r_sinv;

  logic [IW-1:0] w_idx, w_sidx;
  logic [TW-1:0] w_tag, w_stag;
  logic          w_off, w_beat;
  logic          w_match, w_hit, w_req, w_s_hit;
  msi_e          w_msi, w_smsi;
  logic          w_unused;

  assign w_idx    = io_cif.dmemaddr[IW+2:3];
  assign w_tag    = io_cif.dmemaddr[31:IW+3];
  assign w_off    = io_cif.dmemaddr[2];
  assign w_msi    = r_msi[w_idx];
  assign w_match  = (w_msi != MsiI) && (r_tag[w_idx] == w_tag);
  assign w_req    = io_cif.dmemREN | io_cif.dmemWEN;
  assign w_hit    = (r_state == StIdle) && !io_cif.ccwait &&
                    ((io_cif.dmemREN && w_match) || (io_cif.dmemWEN && w_match && w_msi == MsiM));
  assign w_sidx   = io_cif.ccsnoopaddr[IW+2:3];
  assign w_stag   = io_cif.ccsnoopaddr[31:IW+3];
  assign w_smsi   = r_msi[w_sidx];
  assign w_s_hit  = (w_smsi != MsiI) && (r_tag[w_sidx] == w_stag);
  assign w_beat   = (r_state == StWb1) || (r_state == StLd1) || (r_state == StSwb1);
  assign w_unused = ^io_cif.ccsnoopaddr[2:0];

  always_comb begin
    io_cif.dhit     = w_hit;
    io_cif.dmemload = w_hit ? r_data[w_idx][w_off] : 32'h0;
    io_cif.dREN     = 1'b0;
    io_cif.dWEN     = 1'b0;
    io_cif.daddr    = 32'h0;
    io_cif.dstore   = 32'h0;
    io_cif.ccwrite  = 1'b0;
    io_cif.cctrans  = 1'b0;
    unique case (r_state)
      StWb0, StWb1: begin
        io_cif.dWEN   = 1'b1;
        io_cif.daddr  = {r_tag[w_idx], w_idx, w_beat, 2'b00};
        io_cif.dstore = r_data[w_idx][w_beat];
      end
      StLd0, StLd1: begin
        io_cif.dREN    = 1'b1;
        io_cif.cctrans = 1'b1;
        io_cif.ccwrite = io_cif.dmemWEN;
        io_cif.daddr   = {w_tag, w_idx, w_beat, 2'b00};
      end
      StUpg: begin
        io_cif.cctrans = 1'b1;
        io_cif.ccwrite = 1'b1;
        io_cif.daddr   = io_cif.dmemaddr;
      end
      // Only an S-line invalidation is a one-cycle transition; M hits announce it in SWB.
      StSnoop: io_cif.cctrans = w_s_hit && (w_smsi == MsiS) && io_cif.ccinv;
      StSwb0, StSwb1: begin
        io_cif.dWEN    = 1'b1;
        io_cif.cctrans = 1'b1;
        io_cif.daddr   = {r_tag[r_sidx], r_sidx, w_beat, 2'b00};
        io_cif.dstore  = r_data[r_sidx][w_beat];
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= StIdle;
      r_sidx  <= '0;
      r_sinv  <= 1'b0;
      for (int unsigned i = 0; i < SETS; i++) begin
        r_msi[i]     <= MsiI;
        r_tag[i]     <= '0;
        r_data[i][0] <= '0;
        r_data[i][1] <= '0;
      end
    end else begin
      unique case (r_state)
        StIdle: begin
          if (io_cif.ccwait) begin
            r_state <= StSnoop;
          end else if (w_hit) begin
            if (io_cif.dmemWEN) r_data[w_idx][w_off] <= io_cif.dmemstore;
          end else if (w_req) begin
            // A tag match that did not hit can only be a store to an S line.
            if (io_cif.dmemWEN && w_match) r_state <= StUpg;
            else if (w_msi == MsiM)        r_state <= StWb0;
            else                           r_state <= StLd0;
          end
        end
        StWb0: if (!io_cif.dwait) r_state <= StWb1;
        StWb1: if (!io_cif.dwait) r_state <= StLd0;
        StLd0: begin
          if (!io_cif.dwait) begin
            r_data[w_idx][0] <= io_cif.dload;
            r_state          <= StLd1;
          end
        end
        StLd1: begin
          if (!io_cif.dwait) begin
            r_data[w_idx][1] <= io_cif.dload;
            r_tag[w_idx]     <= w_tag;
            r_msi[w_idx]     <= io_cif.dmemWEN ? MsiM : MsiS;
            r_state          <= StIdle;
          end
        end
        StUpg: begin
          if (!io_cif.dwait) begin
            r_msi[w_idx] <= MsiM;
            r_state      <= StIdle;
          end
        end
        StSnoop: begin
          r_sidx <= w_sidx;
          r_sinv <= io_cif.ccinv;
          if (w_s_hit && w_smsi == MsiM) begin
            r_state <= StSwb0;
          end else begin
            if (w_s_hit && io_cif.ccinv) r_msi[w_sidx] <= MsiI;
            r_state <= StIdle;
          end
        end
        StSwb0: if (!io_cif.dwait) r_state <= StSwb1;
        StSwb1: begin
          if (!io_cif.dwait) begin
            r_msi[r_sidx] <= r_sinv ? MsiI : MsiS;
            r_state       <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  a_ccwait_idle: assert property (@(posedge CLK) disable iff (!nRST)
    $rose(io_cif.ccwait) |-> (r_state == StIdle || r_state == StSnoop));
endmodule
